regfile_writeback_unit: RTL
===========================

// Module: regfile_writeback_unit
// PURPOSE
// Write-side driver for the 32x32 register file. Merges single-cycle ALU results and
// multi-cycle load results into the file's single write port (A3/WD3/WE3), one write
// per cycle. Loads queue in a small FIFO; ALU has priority with a starvation guard.
// Also reports pending-write hazards for decode, and never issues a write to x0.
// PARAMETERS
// XLEN        32  data width
// DEPTH       4   load FIFO entries (>=2)
// STARVE_MAX  3   consecutive ALU wins over a non-empty FIFO before ALU is stalled
// PORTS
// clk         in   1              clock, all state on posedge
// rst         in   1              asynchronous reset, active-low
// alu_valid   in   1              ALU result present this cycle
// alu_rd      in   5              ALU destination register
// alu_data    in   XLEN           ALU result
// alu_stall   out  1              ALU result not taken this cycle; upstream holds it
// ld_valid    in   1              load result offered
// ld_rd       in   5              load destination register
// ld_data     in   XLEN           load data
// ld_ready    out  1              FIFO can accept; push on ld_valid&&ld_ready at posedge
// q_rs1,q_rs2 in   5              decode source registers to check
// q_hit1,q_hit2 out 1             pending write to that source exists
// fifo_count  out  $clog2(DEPTH+1) entries queued
// A3          out  5              regfile write address
// WD3         out  XLEN           regfile write data
// WE3         out  1              regfile write enable
// BEHAVIOUR
// - rst=0 (async, immediate): FIFO empty, fifo_count=0, starve_cnt=0, WE3=0, A3=0,
//   WD3=0, ld_ready=0, alu_stall=0. Reset mid-queue discards all entries, no writes.
// - ld_ready = rst && (fifo_count<DEPTH); no same-cycle pop bypass when full.
// - Push with ld_rd=0 is handshaken but discarded (count unchanged).
// - Push at edge N: entry is poppable from cycle after N (no push-to-pop bypass).
// - Per-cycle select, registered into A3/WD3/WE3 (1-cycle latency):
//   1) alu_valid && !alu_stall: A3<=alu_rd, WD3<=alu_data, WE3<=(alu_rd!=0).
//   2) else fifo_count>0: pop head (FIFO order), A3/WD3<=head, WE3<=1.
//   3) else WE3<=0; A3/WD3 hold.
// - Push and pop in same cycle: count unchanged.
// - starve_cnt: +1 on each cycle case 1 occurs with fifo_count>0; cleared on any
//   pop or when fifo_count==0. Saturates at STARVE_MAX.
// - alu_stall = (starve_cnt==STARVE_MAX) && (fifo_count>0), combinational; forces
//   case 2 for that cycle, starve_cnt then clears.
// - q_hitN = (q_rsN!=0) && (any queued entry rd==q_rsN || (WE3 && A3==q_rsN)).
//   Combinational; offered-but-not-pushed ld_rd does not count.
// - Regfile captures on the edge after WE3 is high: end-to-end ALU->file = 2 edges.
// TESTING
// 1. Queue 2 loads, pull rst low mid-cycle -> WE3=0, fifo_count=0, ld_ready=0 at once;
//    release -> ld_ready=1, no stale writes ever appear.
// 2. alu_valid, rd=5, data=0xDEADBEEF -> next cycle WE3=1,A3=5,WD3=0xDEADBEEF;
//    rd=0 -> WE3=0; ld push rd=0 -> fifo_count stays 0.
// 3. Idle ALU, push rd=7 data=0x11 at edge N -> fifo_count=1, WE3=1,A3=7,WD3=0x11
//    after edge N+1, fifo_count=0.
// 4. alu_valid held, rd=1..: push 4 loads -> ld_ready=0 at count=4, 5th ld_valid held
//    not accepted until a pop; FIFO drain order equals push order.
// 5. alu_valid continuous, one load rd=9 queued -> 3 ALU writes, then alu_stall=1 one
//    cycle, rd=9 written, held ALU result written next, alu_stall=0.
// 6. Load rd=9 queued: q_rs1=9 -> q_hit1=1; q_rs2=0 -> q_hit2=0; hit stays 1 while
//    WE3&&A3=9, drops to 0 the cycle after.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// Write-port arbiter for the 32x32 register file: ALU results win the port, load results
// wait in a small FIFO, and a starvation guard forces a load pop after STARVE_MAX ALU wins.
module regfile_writeback_unit #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       alu_stall,
    input  logic                       ld_valid,
    input  logic [4:0]                 ld_rd,
    input  logic [XLEN-1:0]            ld_data,
    output logic                       ld_ready,
    input  logic [4:0]                 q_rs1,
    input  logic [4:0]                 q_rs2,
    output logic                       q_hit1,
    output logic                       q_hit2,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic [4:0]                 A3,
    output logic [XLEN-1:0]            WD3,
    output logic                       WE3
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [PW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg;
    logic [SW-1:0]   starve_reg, starve_next;
    logic            take_alu, fifo_nonempty, pop, push;
    logic [DEPTH-1:0] hit1_vec, hit2_vec;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_count    = count_reg;
    assign fifo_nonempty = (count_reg != '0);
    assign ld_ready      = rst && (count_reg < CW'(DEPTH));
    assign alu_stall     = (starve_reg == SW'(STARVE_MAX)) && fifo_nonempty;
    assign take_alu      = alu_valid && !alu_stall;
    assign pop           = !take_alu && fifo_nonempty;
    // Writes to x0 complete the handshake but never occupy a slot.
    assign push          = ld_valid && ld_ready && (ld_rd != 5'd0);

    // Per-slot valid bits let every queued destination be compared in parallel.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit1_vec[gi] = valid_reg[gi] && (rd_mem[gi] == q_rs1);
            assign hit2_vec[gi] = valid_reg[gi] && (rd_mem[gi] == q_rs2);
        end
    endgenerate

    assign q_hit1 = (q_rs1 != 5'd0) && ((|hit1_vec) || (WE3 && (A3 == q_rs1)));
    assign q_hit2 = (q_rs2 != 5'd0) && ((|hit2_vec) || (WE3 && (A3 == q_rs2)));

    always_comb begin
        valid_next = valid_reg;
        if (pop)  valid_next[head_reg] = 1'b0;
        if (push) valid_next[tail_reg] = 1'b1;
    end

    always_comb begin
        starve_next = starve_reg;
        if (pop || !fifo_nonempty)
            starve_next = '0;
        else if (take_alu && (starve_reg != SW'(STARVE_MAX)))
            starve_next = starve_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail_reg]   <= ld_rd;
            data_mem[tail_reg] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg  <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            A3         <= '0;
            WD3        <= '0;
            WE3        <= 1'b0;
        end else begin
            valid_reg  <= valid_next;
            starve_reg <= starve_next;
            if (push) tail_reg <= ptr_inc(tail_reg);
            if (pop)  head_reg <= ptr_inc(head_reg);
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
            if (take_alu) begin
                A3  <= alu_rd;
                WD3 <= alu_data;
                WE3 <= (alu_rd != 5'd0);
            end else if (pop) begin
                A3  <= rd_mem[head_reg];
                WD3 <= data_mem[head_reg];
                WE3 <= 1'b1;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end
endmodule
